// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants, also used by decode.
package fetch_pkg;

   localparam int unsigned XLEN        = 32;
   localparam int unsigned INSTR_BYTES = 4;
   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry synchronous FIFO of fetch entries; flush wins over push.
module fetch_buffer
   import fetch_pkg::*;
(
   input  logic         clk,
   input  logic         reset,
   input  logic         push_i,
   input  fetch_entry_t entry_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output logic [1:0]   count_o,
   output fetch_entry_t head_o
);

   localparam int unsigned DEPTH = 2;

   fetch_entry_t mem_q [DEPTH];
   fetch_entry_t mem_d [DEPTH];
   logic         rd_q, rd_d;
   logic         wr_q, wr_d;
   logic [1:0]   count_q, count_d;
   logic         pop_ok;

   always_comb begin
      mem_d   = mem_q;
      rd_d    = rd_q;
      wr_d    = wr_q;
      count_d = count_q;
      pop_ok  = pop_i && (count_q != 2'd0);
      if (flush_i) begin
         rd_d    = 1'b0;
         wr_d    = 1'b0;
         count_d = 2'd0;
      end else begin
         if (push_i) begin
            mem_d[wr_q] = entry_i;
            wr_d        = ~wr_q;
         end
         if (pop_ok) begin
            rd_d = ~rd_q;
         end
         count_d = count_q + 2'(push_i) - 2'(pop_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         rd_q    <= 1'b0;
         wr_q    <= 1'b0;
         count_q <= 2'd0;
      end else begin
         mem_q   <= mem_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         count_q <= count_d;
      end
   end

   assign count_o = count_q;
   assign head_o  = mem_q[rd_q];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: PC, one-deep in-flight tracking into a registered-read
// instruction memory, and a 2-entry buffer handing instructions to decode.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter int unsigned         DWIDTH   = XLEN,
   parameter logic [DWIDTH-1:0]   RESET_PC = fetch_pkg::RESET_PC
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetchEnable,
   output logic              memEnable,
   output logic [DWIDTH-1:0] memAddress,
   input  logic [DWIDTH-1:0] memInstruction,
   input  logic              redirectValid,
   input  logic [DWIDTH-1:0] redirectTarget,
   output logic              instrValid,
   output logic [DWIDTH-1:0] instrOut,
   output logic [DWIDTH-1:0] pcOut,
   input  logic              decodeReady
);

   logic [DWIDTH-1:0] pc_q, pc_d;
   logic [DWIDTH-1:0] inflight_pc_q, inflight_pc_d;
   logic              inflight_q, inflight_d;

   logic [1:0]        count;
   fetch_entry_t      head;
   fetch_entry_t      push_entry;
   logic              head_valid;
   logic              pop;
   logic              push;
   logic              issue;
   logic [2:0]        occupancy;

   // Issue looks ahead through this cycle's pop so a full buffer refills without a bubble.
   always_comb begin
      head_valid = (count != 2'd0) && !redirectValid;
      pop        = head_valid && decodeReady;
      occupancy  = 3'(count) - 3'(pop) + 3'(inflight_q);
      issue      = fetchEnable && (occupancy < 3'd2);
      memEnable  = issue || redirectValid;
      memAddress = redirectValid ? {redirectTarget[DWIDTH-1:2], 2'b00} : pc_q;

      pc_d          = pc_q;
      inflight_d    = 1'b0;
      inflight_pc_d = inflight_pc_q;
      if (memEnable) begin
         pc_d          = memAddress + DWIDTH'(INSTR_BYTES);
         inflight_d    = 1'b1;
         inflight_pc_d = memAddress;
      end

      // A redirect kills the response landing this cycle.
      push             = inflight_q && !redirectValid;
      push_entry.pc    = inflight_pc_q;
      push_entry.instr = memInstruction;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q          <= RESET_PC;
         inflight_q    <= 1'b0;
         inflight_pc_q <= '0;
      end else begin
         pc_q          <= pc_d;
         inflight_q    <= inflight_d;
         inflight_pc_q <= inflight_pc_d;
      end
   end

   fetch_buffer u_buf (
      .clk     (clk),
      .reset   (reset),
      .push_i  (push),
      .entry_i (push_entry),
      .pop_i   (pop),
      .flush_i (redirectValid),
      .count_o (count),
      .head_o  (head)
   );

   assign instrValid = head_valid;
   assign instrOut   = head_valid ? head.instr : '0;
   assign pcOut      = head_valid ? head.pc    : '0;

endmodule
